// File: rtl/gmii_tx_sequencer_pkg.sv
// Shared definitions for the GMII transmit sequencer.
// Holds the FSM state encoding, the fixed GMII byte values and the widths
// of the internal counters.
package gmii_tx_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_ABORT,
        ST_DISCARD,
        ST_IPG
    } state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam logic [7:0] PAD_BYTE      = 8'h00;

    // Width of the interval down-counter (preamble, pad and gap lengths)
    localparam int GAP_W  = 8;
    // Width of the per-frame byte counter (saturates at 2047)
    localparam int BCNT_W = 11;

endpackage

// File: rtl/gmii_tx_sequencer_if.sv
// Source byte-stream interface feeding the GMII transmit sequencer.
//   in_valid : source byte valid
//   in_data  : source byte
//   in_last  : final byte of a frame (qualified by in_valid)
//   in_ready : sequencer consumes in_data when in_valid & in_ready
// master = byte source, slave = sequencer.
interface gmii_tx_sequencer_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/gmii_tx_sequencer_gap_counter.sv
// tx_gap_counter: loadable down-counter used to time the preamble, pad and
// inter-packet-gap intervals.
//   clk    : clock
//   rst    : synchronous active-high reset
//   load   : load 'value' (has priority over enable)
//   value  : count to load
//   enable : decrement while nonzero
//   zero   : count is zero
module tx_gap_counter
    import gmii_tx_sequencer_pkg::*;
#(
    parameter int W = GAP_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         enable,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (enable && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/gmii_tx_sequencer.sv
// gmii_tx_sequencer: MAC-side transmit controller driving the PCS over GMII.
// Takes frames from a valid/ready byte stream, prepends preamble and SFD,
// pads short frames, enforces the inter-packet gap and aborts on underrun.
//   GTX_CLK       : transmit clock
//   mr_main_reset : synchronous active-high reset
//   xmit          : PCS in DATA mode (new frames may start)
//   src           : source byte stream (slave side)
//   TX_EN/TXD/TX_ER : registered GMII transmit outputs
//   busy          : state is not IDLE
//   frames_sent   : completed frames, wrapping
//   aborts        : aborted frames, saturating
//
// The output registers load from the current state, so what a state decides
// appears on GMII one cycle later. The start decision in IDLE already emits
// the first preamble byte, which lets DATA be entered while the SFD is on the
// wire and the first data byte follow the SFD without a bubble.
module gmii_tx_sequencer
    import gmii_tx_sequencer_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int IPG_LEN      = 12,
    parameter int PAD_MIN      = 60
) (
    input  logic                 GTX_CLK,
    input  logic                 mr_main_reset,
    input  logic                 xmit,
    gmii_tx_sequencer_if.slave   src,
    output logic                 TX_EN,
    output logic [7:0]           TXD,
    output logic                 TX_ER,
    output logic                 busy,
    output logic [15:0]          frames_sent,
    output logic [7:0]           aborts
);

    localparam logic [BCNT_W-1:0] PAD_MIN_C = BCNT_W'(PAD_MIN);
    // One preamble byte is emitted by the IDLE start decision
    localparam logic [GAP_W-1:0]  PRE_LOAD  = GAP_W'(PREAMBLE_LEN - 2);
    localparam logic [GAP_W-1:0]  IPG_LOAD  = GAP_W'(IPG_LEN - 1);
    // The ABORT cycle already counts as the first idle cycle
    localparam logic [GAP_W-1:0]  DISC_LOAD = GAP_W'(IPG_LEN - 2);

    function automatic logic [BCNT_W-1:0] sat_inc_bcnt(input logic [BCNT_W-1:0] v);
        return (&v) ? v : v + BCNT_W'(1);
    endfunction

    function automatic logic [7:0] sat_inc_abort(input logic [7:0] v);
        return (&v) ? v : v + 8'd1;
    endfunction

    state_t             state, next_state;
    logic [BCNT_W-1:0]  byte_cnt, byte_cnt_inc;
    logic               gap_load, gap_en, gap_zero;
    logic [GAP_W-1:0]   gap_value;
    logic               tx_en_d, tx_er_d;
    logic [7:0]         txd_d;
    logic               frame_done, frame_abort, frame_start, byte_take;

    tx_gap_counter #(.W(GAP_W)) u_gap (
        .clk    (GTX_CLK),
        .rst    (mr_main_reset),
        .load   (gap_load),
        .value  (gap_value),
        .enable (gap_en),
        .zero   (gap_zero)
    );

    assign byte_cnt_inc = sat_inc_bcnt(byte_cnt);
    assign src.in_ready = (state == ST_DATA) || (state == ST_DISCARD);
    assign busy         = (state != ST_IDLE);

    always_comb begin
        next_state  = state;
        gap_load    = 1'b0;
        gap_value   = '0;
        gap_en      = 1'b0;
        tx_en_d     = 1'b0;
        tx_er_d     = 1'b0;
        txd_d       = PAD_BYTE;
        frame_done  = 1'b0;
        frame_abort = 1'b0;
        frame_start = 1'b0;
        byte_take   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (xmit && src.in_valid) begin
                    next_state  = ST_PREAMBLE;
                    frame_start = 1'b1;
                    gap_load    = 1'b1;
                    gap_value   = PRE_LOAD;
                    tx_en_d     = 1'b1;
                    txd_d       = PREAMBLE_BYTE;
                end
            end
            ST_PREAMBLE: begin
                tx_en_d = 1'b1;
                txd_d   = PREAMBLE_BYTE;
                gap_en  = 1'b1;
                if (gap_zero) next_state = ST_SFD;
            end
            ST_SFD: begin
                tx_en_d    = 1'b1;
                txd_d      = SFD_BYTE;
                next_state = ST_DATA;
            end
            ST_DATA: begin
                tx_en_d = 1'b1;
                if (src.in_valid) begin
                    txd_d     = src.in_data;
                    byte_take = 1'b1;
                    if (src.in_last) begin
                        gap_load = 1'b1;
                        if (byte_cnt_inc < PAD_MIN_C) begin
                            next_state = ST_PAD;
                            gap_value  = GAP_W'(PAD_MIN_C - byte_cnt_inc - BCNT_W'(1));
                        end else begin
                            next_state = ST_IPG;
                            gap_value  = IPG_LOAD;
                            frame_done = 1'b1;
                        end
                    end
                end else begin
                    // Underrun: the abort marker goes out while ABORT is current
                    tx_er_d     = 1'b1;
                    next_state  = ST_ABORT;
                    frame_abort = 1'b1;
                end
            end
            ST_PAD: begin
                tx_en_d = 1'b1;
                gap_en  = 1'b1;
                if (gap_zero) begin
                    next_state = ST_IPG;
                    gap_load   = 1'b1;
                    gap_value  = IPG_LOAD;
                    frame_done = 1'b1;
                end
            end
            ST_ABORT: begin
                next_state = ST_DISCARD;
                gap_load   = 1'b1;
                gap_value  = DISC_LOAD;
            end
            ST_DISCARD: begin
                // Gap keeps running while the rest of the frame is dropped
                gap_en = 1'b1;
                if (src.in_valid && src.in_last) begin
                    next_state = gap_zero ? ST_IDLE : ST_IPG;
                end
            end
            ST_IPG: begin
                gap_en = 1'b1;
                if (gap_zero) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge GTX_CLK) begin
        if (mr_main_reset) begin
            state       <= ST_IDLE;
            TX_EN       <= 1'b0;
            TX_ER       <= 1'b0;
            TXD         <= 8'h00;
            byte_cnt    <= '0;
            frames_sent <= 16'd0;
            aborts      <= 8'd0;
        end else begin
            state <= next_state;
            TX_EN <= tx_en_d;
            TX_ER <= tx_er_d;
            TXD   <= txd_d;
            if (frame_start) begin
                byte_cnt <= '0;
            end else if (byte_take) begin
                byte_cnt <= byte_cnt_inc;
            end
            if (frame_done)  frames_sent <= frames_sent + 16'd1;
            if (frame_abort) aborts      <= sat_inc_abort(aborts);
        end
    end

endmodule

// File: tb/tb_gmii_tx_sequencer.sv
// Bench for gmii_tx_sequencer: directed frames with a scoreboard of the
// expected GMII byte stream, popped by a monitor whenever TX_EN is high.
module tb_gmii_tx_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        xmit;
    logic        TX_EN, TX_ER, busy;
    logic [7:0]  TXD, aborts;
    logic [15:0] frames_sent;

    gmii_tx_sequencer_if src_if ();

    gmii_tx_sequencer dut (
        .GTX_CLK       (clk),
        .mr_main_reset (rst),
        .xmit          (xmit),
        .src           (src_if),
        .TX_EN         (TX_EN),
        .TXD           (TXD),
        .TX_ER         (TX_ER),
        .busy          (busy),
        .frames_sent   (frames_sent),
        .aborts        (aborts)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q [$];
    logic sb_en = 1'b1;

    // burst / gap tracking
    logic prev_en = 1'b0;
    logic seen_high = 1'b0;
    int   high_run = 0;
    int   low_run = 0;
    int   last_burst = 0;
    int   last_gap = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (TX_EN) begin
            if (sb_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected actual TXD=0x%0h TX_ER=%0b expected no output", TXD, TX_ER);
                end else begin
                    chk("sb_byte", {23'd0, TX_ER, TXD}, {23'd0, exp_q.pop_front()});
                end
            end
            if (!prev_en) begin
                if (seen_high) last_gap = low_run;
                high_run = 0;
            end
            high_run++;
            seen_high = 1'b1;
        end else begin
            chk("er_while_idle", {31'd0, TX_ER}, 32'd0);
            if (prev_en) begin
                last_burst = high_run;
                low_run = 1;
            end else begin
                low_run++;
            end
        end
        prev_en = TX_EN;
    end

    task automatic push_frame(input int len, input int base, input int abort_after);
        logic [7:0] b;
        for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
        if (abort_after >= 0) begin
            for (int i = 0; i <= abort_after; i++) begin
                b = 8'(base + i);
                exp_q.push_back({1'b0, b});
            end
            exp_q.push_back({1'b1, 8'h00});
        end else begin
            for (int i = 0; i < len; i++) begin
                b = 8'(base + i);
                exp_q.push_back({1'b0, b});
            end
            for (int i = len; i < 60; i++) exp_q.push_back({1'b0, 8'h00});
        end
    endtask

    // Presents bytes base..base+len-1; optional stall after byte index
    // stall_after, optional early return after stop_after accepted bytes.
    task automatic send_frame(input int len, input int base, input int stall_after,
                              input int stall_cycles, input int stop_after);
        int i = 0;
        int cyc = 0;
        logic rdy;
        while (i < len) begin
            src_if.in_valid = 1'b1;
            src_if.in_data  = 8'(base + i);
            src_if.in_last  = (i == len - 1);
            @(negedge clk);
            rdy = src_if.in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                i++;
                if (i == stop_after) return;
                if (stall_after >= 0 && i == stall_after + 1) begin
                    src_if.in_valid = 1'b0;
                    repeat (stall_cycles) @(posedge clk);
                    #1;
                end
            end
            cyc++;
            if (cyc > 3000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout actual accepted=%0d required=%0d", i, len);
                break;
            end
        end
        src_if.in_valid = 1'b0;
        src_if.in_last  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        xmit = 1'b1;
        src_if.in_valid = 1'b0;
        src_if.in_data  = 8'h00;
        src_if.in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_tx_en", {31'd0, TX_EN}, 32'd0);
        chk("rst_tx_er", {31'd0, TX_ER}, 32'd0);
        chk("rst_txd", {24'd0, TXD}, 32'd0);
        chk("rst_in_ready", {31'd0, src_if.in_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frames", {16'd0, frames_sent}, 32'd0);
        chk("rst_aborts", {24'd0, aborts}, 32'd0);

        // 64-byte frame, no stalls
        push_frame(64, 8'h00, -1);
        send_frame(64, 8'h00, -1, 0, -1);
        wait_idle("t1_idle");
        chk("t1_burst", last_burst, 72);
        chk("t1_frames", {16'd0, frames_sent}, 32'd1);
        chk("t1_aborts", {24'd0, aborts}, 32'd0);

        // 10-byte frame padded to 60
        push_frame(10, 8'hA0, -1);
        send_frame(10, 8'hA0, -1, 0, -1);
        @(negedge clk);
        chk("t2_pad_in_ready", {31'd0, src_if.in_ready}, 32'd0);
        chk("t2_pad_tx_en", {31'd0, TX_EN}, 32'd1);
        wait_idle("t2_idle");
        chk("t2_burst", last_burst, 68);
        chk("t2_frames", {16'd0, frames_sent}, 32'd2);

        // back-to-back 64-byte frames
        push_frame(64, 8'h10, -1);
        push_frame(64, 8'h60, -1);
        send_frame(64, 8'h10, -1, 0, -1);
        send_frame(64, 8'h60, -1, 0, -1);
        wait_idle("t3_idle");
        chk("t3_gap", last_gap, 12);
        chk("t3_burst", last_burst, 72);
        chk("t3_frames", {16'd0, frames_sent}, 32'd4);

        // xmit low holds off the start
        xmit = 1'b0;
        push_frame(60, 8'h40, -1);
        fork
            send_frame(60, 8'h40, -1, 0, -1);
            begin
                repeat (20) @(negedge clk);
                chk("t4_hold_tx_en", {31'd0, TX_EN}, 32'd0);
                chk("t4_hold_in_ready", {31'd0, src_if.in_ready}, 32'd0);
                chk("t4_hold_busy", {31'd0, busy}, 32'd0);
                @(posedge clk);
                #1 xmit = 1'b1;
                @(negedge clk);
                chk("t4_pre_t0_tx_en", {31'd0, TX_EN}, 32'd0);
                @(negedge clk);
                chk("t4_start_tx_en", {31'd0, TX_EN}, 32'd1);
                chk("t4_start_txd", {24'd0, TXD}, 32'h55);
            end
        join
        wait_idle("t4_idle");
        chk("t4_burst", last_burst, 68);
        chk("t4_frames", {16'd0, frames_sent}, 32'd5);

        // underrun after data byte 5
        push_frame(20, 8'h10, 5);
        send_frame(20, 8'h10, 5, 3, -1);
        wait_idle("t5_idle");
        chk("t5_burst", last_burst, 15);
        chk("t5_aborts", {24'd0, aborts}, 32'd1);
        chk("t5_frames", {16'd0, frames_sent}, 32'd5);

        // reset during DATA, then an immediate new frame
        sb_en = 1'b0;
        send_frame(64, 8'h80, -1, 0, 10);
        rst = 1'b1;
        src_if.in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        sb_en = 1'b1;
        push_frame(60, 8'hC0, -1);
        fork
            send_frame(60, 8'hC0, -1, 0, -1);
            begin
                @(negedge clk);
                chk("t6_tx_en", {31'd0, TX_EN}, 32'd0);
                chk("t6_busy", {31'd0, busy}, 32'd0);
                chk("t6_frames", {16'd0, frames_sent}, 32'd0);
                chk("t6_aborts", {24'd0, aborts}, 32'd0);
            end
        join
        wait_idle("t6_idle");
        chk("t6_gap", last_gap, 1);
        chk("t6_frames_after", {16'd0, frames_sent}, 32'd1);
        chk("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog actual=timeout required=completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
